// File: rtl/axis_sf_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_sf_packet_fifo
// Purpose  : Store-and-forward AXI-Stream packet FIFO. A packet becomes
//            visible on the master side only once its last beat has been
//            stored. m_valid_o therefore never drops inside a packet because
//            of the upstream producer.
// Config   : AXIS_SF_DROP_OVERSIZE_EN (define to enable)
//            defined   - packets longer than DEPTH beats are discarded and
//                        reported with a one-cycle drop_pulse_o
//            undefined - no drop FSM, drop_pulse_o tied low. Oversize
//                        packets are illegal and stall with s_ready_o low.
// Ports    : clk           clock, all logic on the rising edge
//            rst           asynchronous active-high reset
//            s_valid_i     slave beat valid
//            s_ready_o     slave beat ready (registers only, not s_valid_i)
//            s_data_i      slave data, word i at [i*WORD_W +: WORD_W]
//            s_keep_i      slave per-word keep (stored unmodified)
//            s_last_i      slave end of packet
//            m_valid_o     master beat valid (committed data available)
//            m_ready_i     master beat ready
//            m_data_o      master data
//            m_keep_o      master keep
//            m_last_o      master end of packet
//            pkt_count_o   number of complete packets stored
//            drop_pulse_o  one-cycle pulse when an oversize packet ends
// Revision : 1.0  initial release
// ============================================================================
module axis_sf_packet_fifo #(
  parameter int WORD_W = 8,
  parameter int BUS_W  = 32,
  parameter int DEPTH  = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid_i,
  output logic                                s_ready_o,
  input  logic [(BUS_W/WORD_W)*WORD_W-1:0]    s_data_i,
  input  logic [BUS_W/WORD_W-1:0]             s_keep_i,
  input  logic                                s_last_i,
  output logic                                m_valid_o,
  input  logic                                m_ready_i,
  output logic [(BUS_W/WORD_W)*WORD_W-1:0]    m_data_o,
  output logic [BUS_W/WORD_W-1:0]             m_keep_o,
  output logic                                m_last_o,
  output logic [$clog2(DEPTH):0]              pkt_count_o,
  output logic                                drop_pulse_o
);

  localparam int c_wpb = BUS_W / WORD_W;
  localparam int c_dw  = c_wpb * WORD_W;
  localparam int c_aw  = $clog2(DEPTH);
  localparam int c_pw  = c_aw + 1;

  localparam logic [c_pw-1:0] c_depth    = c_pw'(DEPTH);
  localparam logic [c_pw-1:0] c_ptr_one  = c_pw'(1);
  localparam logic [c_aw-1:0] c_last_idx = c_aw'(DEPTH - 1);

  // Storage
  logic [c_dw-1:0]  mem_data_q [DEPTH];
  logic [c_wpb-1:0] mem_keep_q [DEPTH];
  logic             mem_last_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [c_pw-1:0] wr_ptr_q,     wr_ptr_d;
  logic [c_pw-1:0] commit_ptr_q, commit_ptr_d;
  logic [c_pw-1:0] rd_ptr_q,     rd_ptr_d;
  logic [c_pw-1:0] pkt_count_q,  pkt_count_d;
  logic [c_aw-1:0] beat_cnt_q,   beat_cnt_d;
  logic            rdy_en_q;

  logic [c_pw-1:0] w_used;
  logic            w_full;
  logic            w_accept;
  logic            w_wr;
  logic            w_commit;
  logic            w_rd;
  logic            w_rd_last;
  logic            w_cnt_at_max;
  logic            w_in_drop;
  logic            w_drop_start;

  assign w_used       = wr_ptr_q - rd_ptr_q;
  assign w_full       = (w_used == c_depth);
  assign w_cnt_at_max = (beat_cnt_q == c_last_idx);

`ifdef AXIS_SF_DROP_OVERSIZE_EN
  localparam logic [0:0] c_st_accept = 1'b0;
  localparam logic [0:0] c_st_drop   = 1'b1;

  logic [0:0] state_q, state_d;
  logic       drop_pulse_q;
  logic       w_drop_end;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_st_accept;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_accept: if (w_accept && !s_last_i && w_cnt_at_max) state_d = c_st_drop;
      c_st_drop:   if (w_accept && s_last_i)                  state_d = c_st_accept;
      default:     state_d = c_st_accept;
    endcase
  end

  assign w_in_drop = (state_q == c_st_drop);

  // Output logic
  always_comb begin
    w_drop_start = 1'b0;
    w_drop_end   = 1'b0;
    if (state_q == c_st_accept) begin
      // The DEPTH-th beat is not last: the packet can never fit
      w_drop_start = w_accept && !s_last_i && w_cnt_at_max;
    end else begin
      w_drop_end   = w_accept && s_last_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= w_drop_end;
    end
  end

  assign drop_pulse_o = drop_pulse_q;
`else
  assign w_in_drop    = 1'b0;
  assign w_drop_start = 1'b0;
  assign drop_pulse_o = 1'b0;

`ifndef SYNTHESIS
  // A packet longer than DEPTH beats can never be committed
  a_no_oversize_packet: assert property (@(posedge clk) disable iff (rst)
    !(w_accept && !s_last_i && w_cnt_at_max));
`endif
`endif

  // While dropping, beats are swallowed regardless of occupancy
  assign s_ready_o = rdy_en_q && (w_in_drop || !w_full);
  assign w_accept  = s_valid_i && s_ready_o;
  assign w_wr      = w_accept && !w_in_drop;
  assign w_commit  = w_wr && s_last_i;

  assign m_valid_o = (rd_ptr_q != commit_ptr_q);
  assign m_data_o  = mem_data_q[rd_ptr_q[c_aw-1:0]];
  assign m_keep_o  = mem_keep_q[rd_ptr_q[c_aw-1:0]];
  assign m_last_o  = mem_last_q[rd_ptr_q[c_aw-1:0]];
  assign w_rd      = m_valid_o && m_ready_i;
  assign w_rd_last = w_rd && m_last_o;

  assign pkt_count_o = pkt_count_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_count_d  = pkt_count_q;
    beat_cnt_d   = beat_cnt_q;

    // Rewinding to commit_ptr throws away the partial oversize packet
    if (w_drop_start) begin
      wr_ptr_d = commit_ptr_q;
    end else if (w_wr) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
    end

    if (w_commit) begin
      commit_ptr_d = wr_ptr_q + c_ptr_one;
    end

    if (w_rd) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end

    case ({w_commit, w_rd_last})
      2'b10:   pkt_count_d = pkt_count_q + c_ptr_one;
      2'b01:   pkt_count_d = pkt_count_q - c_ptr_one;
      default: pkt_count_d = pkt_count_q;
    endcase

    if (w_commit || w_drop_start) begin
      beat_cnt_d = '0;
    end else if (w_wr) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      beat_cnt_q   <= '0;
      rdy_en_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      beat_cnt_q   <= beat_cnt_d;
      // Holds s_ready_o low until the first edge after reset release
      rdy_en_q     <= 1'b1;
    end
  end

  // Storage array carries no reset; only the pointers define its content
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_data_q[wr_ptr_q[c_aw-1:0]] <= s_data_i;
      mem_keep_q[wr_ptr_q[c_aw-1:0]] <= s_keep_i;
      mem_last_q[wr_ptr_q[c_aw-1:0]] <= s_last_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_sf_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_sf_packet_fifo
// Purpose  : Self-checking directed bench for axis_sf_packet_fifo
//            (WORD_W=8, BUS_W=32, DEPTH=64).
// Revision : 1.0  initial release
// ============================================================================
module tb_axis_sf_packet_fifo;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic [6:0]  pkt_count;
  logic        drop_pulse;

  always #5 clk = ~clk;

  axis_sf_packet_fifo #(
    .WORD_W(8),
    .BUS_W (32),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .s_keep_i    (s_keep),
    .s_last_i    (s_last),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .m_keep_o    (m_keep),
    .m_last_o    (m_last),
    .pkt_count_o (pkt_count),
    .drop_pulse_o(drop_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: records every master handshake, counts in-packet gaps
  // and drop pulses. Only this process writes these variables.
  logic [36:0] rx_mem [0:1023];
  int rx_wr    = 0;
  int gap_cnt  = 0;
  int drop_cnt = 0;
  bit in_pkt   = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 1'b0;
    end else begin
      if (drop_pulse) drop_cnt++;
      if (in_pkt && !m_valid) gap_cnt++;
      if (m_valid && m_ready) begin
        rx_mem[rx_wr[9:0]] = {m_last, m_keep, m_data};
        rx_wr++;
        in_pkt = !m_last;
      end
    end
  end

  logic [36:0] exp_q [$];
  int rx_rd = 0;

  function automatic logic [31:0] mkdata(input int p, input int b);
    return {8'(p), 8'(b), 8'(p * 7 + b), 8'hA5 ^ 8'(b)};
  endfunction

  // Entered and left just after a rising edge
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_pkt(input int p, input int n, input logic [3:0] lastkeep,
                          input bit push, input bit gaps);
    logic [3:0] k;
    logic       l;
    for (int b = 0; b < n; b++) begin
      if (gaps && (b % 10 == 9)) begin
        @(posedge clk);
        #1;
      end
      l = (b == n - 1);
      k = l ? lastkeep : 4'hF;
      if (push) exp_q.push_back({l, k, mkdata(p, b)});
      send_beat(mkdata(p, b), k, l);
    end
  endtask

  task automatic wait_and_compare(input string tag);
    int n = 0;
    logic [36:0] e;
    logic [36:0] a;
    while ((rx_wr - rx_rd) < exp_q.size() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_count"}, 64'(rx_wr - rx_rd), 64'(exp_q.size()));
    while (exp_q.size() > 0 && rx_rd < rx_wr) begin
      e = exp_q.pop_front();
      a = rx_mem[rx_rd[9:0]];
      rx_rd++;
      check({tag, "_data"}, 64'(a[31:0]),  64'(e[31:0]));
      check({tag, "_keep"}, 64'(a[35:32]), 64'(e[35:32]));
      check({tag, "_last"}, 64'(a[36]),    64'(e[36]));
    end
    exp_q.delete();
    rx_rd = rx_wr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required completion");
    $fatal(1, "watchdog");
  end

  bit rnd_on;
`ifdef AXIS_SF_DROP_OVERSIZE_EN
  bit watch_on;
  int pmax;
  int drop_base;
`endif

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready",   64'(s_ready),    64'(0));
    check("rst_m_valid",   64'(m_valid),    64'(0));
    check("rst_pkt_count", 64'(pkt_count),  64'(0));
    check("rst_drop",      64'(drop_pulse), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;

    // Test 1: one 5-beat packet, latency and back-to-back streaming
    m_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back({1'b0, 4'hF, mkdata(1, b)});
      send_beat(mkdata(1, b), 4'hF, 1'b0);
    end
    exp_q.push_back({1'b1, 4'hF, mkdata(1, 4)});
    s_valid = 1'b1;
    s_data  = mkdata(1, 4);
    s_keep  = 4'hF;
    s_last  = 1'b1;
    @(negedge clk);
    check("t1_mvalid_pre", 64'(m_valid),   64'(0));
    check("t1_pkt_pre",    64'(pkt_count), 64'(0));
    check("t1_ready",      64'(s_ready),   64'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("t1_mvalid", 64'(m_valid),   64'(1));
    check("t1_pkt",    64'(pkt_count), 64'(1));
    check("t1_first",  64'(m_data),    64'(mkdata(1, 0)));
    check("t1_mlast0", 64'(m_last),    64'(0));
    @(posedge clk);
    #1;
    wait_and_compare("t1");
    check("t1_pkt_end", 64'(pkt_count), 64'(0));
    @(posedge clk);
    #1;

    // Test 2: 1, 7 and 64-beat packets with input gaps and random m_ready
    rnd_on = 1'b1;
    fork
      begin
        send_pkt(2, 1,  4'h3, 1'b1, 1'b1);
        send_pkt(3, 7,  4'h3, 1'b1, 1'b1);
        send_pkt(4, 64, 4'h3, 1'b1, 1'b1);
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          m_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    wait_and_compare("t2");
    check("t2_pkt_end", 64'(pkt_count), 64'(0));
    @(posedge clk);
    #1;

    // Test 3: fill with 64 single-beat packets, then free one slot
    m_ready = 1'b0;
    for (int p = 0; p < DEPTH; p++) send_pkt(20 + p, 1, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    check("t3_full_ready", 64'(s_ready),   64'(0));
    check("t3_pkt_full",   64'(pkt_count), 64'(DEPTH));
    check("t3_mvalid",     64'(m_valid),   64'(1));
    check("t3_hold_data",  64'(m_data),    64'(mkdata(20, 0)));
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("t3_ready_freed", 64'(s_ready),   64'(1));
    check("t3_pkt_63",      64'(pkt_count), 64'(DEPTH - 1));
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_and_compare("t3");
    @(posedge clk);
    #1;

    // Test 4: B commits in the same cycle A's last beat is read
    m_ready = 1'b0;
    send_pkt(5, 3, 4'hF, 1'b1, 1'b0);
    for (int b = 0; b < 2; b++) begin
      exp_q.push_back({1'b0, 4'hF, mkdata(6, b)});
      send_beat(mkdata(6, b), 4'hF, 1'b0);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    exp_q.push_back({1'b1, 4'h3, mkdata(6, 2)});
    s_valid = 1'b1;
    s_data  = mkdata(6, 2);
    s_keep  = 4'h3;
    s_last  = 1'b1;
    @(negedge clk);
    check("t4_a_last",    64'(m_last),    64'(1));
    check("t4_pkt_pre",   64'(pkt_count), 64'(1));
    check("t4_ready",     64'(s_ready),   64'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("t4_pkt_same",  64'(pkt_count), 64'(1));
    check("t4_b_valid",   64'(m_valid),   64'(1));
    check("t4_b_first",   64'(m_data),    64'(mkdata(6, 0)));
    @(posedge clk);
    #1;
    wait_and_compare("t4");
    check("t4_pkt_end", 64'(pkt_count), 64'(0));
    @(posedge clk);
    #1;

    // Test 5: reset mid-packet with one committed packet stored
    m_ready = 1'b0;
    send_pkt(7, 2, 4'hF, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) send_beat(mkdata(8, b), 4'hF, 1'b0);
    @(negedge clk);
    check("t5_pkt_pre",    64'(pkt_count), 64'(1));
    check("t5_mvalid_pre", 64'(m_valid),   64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_mvalid", 64'(m_valid),   64'(0));
    check("t5_rst_pkt",    64'(pkt_count), 64'(0));
    check("t5_rst_ready",  64'(s_ready),   64'(0));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_rd = rx_wr;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send_pkt(9, 2, 4'hF, 1'b1, 1'b0);
    wait_and_compare("t5");
    @(posedge clk);
    #1;

`ifdef AXIS_SF_DROP_OVERSIZE_EN
    // Test 6: oversize packet dropped, following packet intact
    m_ready   = 1'b1;
    drop_base = drop_cnt;
    pmax      = 0;
    watch_on  = 1'b1;
    fork
      begin
        send_pkt(10, 70, 4'hF, 1'b0, 1'b0);
        send_pkt(11, 4,  4'h3, 1'b1, 1'b0);
        wait_and_compare("t6");
        watch_on = 1'b0;
      end
      begin
        while (watch_on) begin
          @(negedge clk);
          if (int'(pkt_count) > pmax) pmax = int'(pkt_count);
        end
      end
    join
    check("t6_drops",    64'(drop_cnt - drop_base), 64'(1));
    check("t6_pkt_peak", 64'(pmax),                 64'(1));
`else
    check("no_drop_pulse", 64'(drop_cnt), 64'(0));
`endif

    check("no_mvalid_gaps", 64'(gap_cnt),       64'(0));
    check("no_extra_beats", 64'(rx_wr - rx_rd), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
